// File: rtl/instr_mem_loader.sv
// Instruction memory loader: streams a program into a 2**ADDR_W byte memory, then serves combinational fetches (optional LOADER_CHECKSUM_EN).
// Latency: a byte is written on the edge it is accepted and done rises on that edge for the final byte; load_ready drops whenever the loader is not in LOAD.
module instr_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [ADDR_W:0]   load_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic                load_ready_q, load_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                xfer;
  logic                at_last_addr;
  logic [DATA_W-1:0]   mem_q [DEPTH];
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   checksum_q, checksum_d;
`endif

  // load_ready_q is only high in LOAD, so it alone qualifies a transfer
  assign xfer         = load_valid & load_ready_q;
  assign at_last_addr = (addr_q == ADDR_LAST);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    load_count_d = load_count_q;
    load_ready_d = load_ready_q;
    busy_d       = busy_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
`ifdef LOADER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          state_d      = ST_LOAD;
          addr_d       = '0;
          load_count_d = '0;
          load_ready_d = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          ovf_d        = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          checksum_d   = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          load_count_d = load_count_q + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
          checksum_d   = checksum_q + load_data;
`endif
          // The top address is terminal: addr holds there instead of wrapping
          if (!at_last_addr) begin
            addr_d = addr_q + ADDR_W'(1);
          end
          if (load_last || at_last_addr) begin
            state_d      = ST_DONE;
            load_ready_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            ovf_d        = ~load_last;
          end
        end
      end
      default: begin
        state_d      = ST_IDLE;
        load_ready_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        ovf_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      load_count_q <= '0;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      load_count_q <= load_count_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  // Program memory survives reset so a core can restart on the retained image
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem_q[addr_q] <= load_data;
    end
  end

  assign fetch_data = busy_q ? '0 : mem_q[fetch_addr];
  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf        = ovf_q;
  assign load_count = load_count_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter: ADDR_W, default 8, address width; memory depth SHALL be 2**ADDR_W bytes.
REQ-002 Parameter: DATA_W, default 8, instruction width.
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-low.
REQ-005 Port: load_start  input  1  begin a program load at address 0.
REQ-006 Port: load_valid  input  1  load_data holds a valid byte.
REQ-007 Port: load_data  input  DATA_W  program byte.
REQ-008 Port: load_last  input  1  qualifies the current byte as the final byte of the program.
REQ-009 Port: load_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port: fetch_addr  input  ADDR_W  program-counter read address.
REQ-011 Port: fetch_data  output  DATA_W  instruction code returned to the fetch stage.
REQ-012 Port: busy  output  1  load in progress; core SHALL be held in reset while high.
REQ-013 Port: done  output  1  last load completed.
REQ-014 Port: ovf  output  1  last load ran past the final address without load_last.
REQ-015 Port: load_count  output  ADDR_W+1  number of bytes accepted in the current or last load.

Function
REQ-016 FSM states: IDLE, LOAD, DONE.
REQ-017 IDLE: load_ready=0, busy=0, done=0; load_start=1 -> LOAD next cycle, write address and load_count cleared to 0.
REQ-018 LOAD: load_ready=1, busy=1; a transfer occurs on a rising edge with load_valid=1 and load_ready=1.
REQ-019 Each transfer writes mem[addr]=load_data, increments addr and load_count by 1.
REQ-020 Transfer with load_last=1 -> DONE next cycle, ovf=0.
REQ-021 Transfer at addr=2**ADDR_W-1 with load_last=0 -> DONE next cycle, ovf=1; addr does not wrap and no further write occurs.
REQ-022 Transfer at addr=2**ADDR_W-1 with load_last=1 -> DONE, ovf=0.
REQ-023 DONE: done=1, busy=0, load_ready=0; load_start=1 -> LOAD, clearing done, ovf, addr, load_count.
REQ-024 load_start while in LOAD SHALL be ignored; the load continues.
REQ-025 load_start and load_valid in the same cycle from IDLE/DONE: byte not accepted (load_ready=0 that cycle).
REQ-026 load_valid=0 in LOAD: no write, no state change; stalls of any length allowed.
REQ-027 fetch_data SHALL be combinational mem[fetch_addr] when busy=0, and 0 when busy=1.
REQ-028 Reads never modify memory; fetch_addr may change every cycle with zero-cycle latency.

Reset
REQ-029 reset=0 SHALL force, asynchronously, state=IDLE, addr=0, load_count=0, done=0, ovf=0, load_ready=0, busy=0.
REQ-030 Memory contents are not cleared by reset; after reset, fetch_data reflects retained contents.
REQ-031 Reset during LOAD aborts the load; bytes already written remain in memory, subsequent bytes are not written.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN: when defined, port checksum output DATA_W SHALL exist, equal to the modulo-2**DATA_W sum of all bytes accepted since the last load_start; cleared by load_start and reset; held in DONE.
REQ-033 Without LOADER_CHECKSUM_EN, the checksum port and adder SHALL be absent; all other behaviour identical.

Verification
REQ-034 Load 0x05,0x41,0xC2(last) with no stalls -> done=1 two cycles later, load_count=3, ovf=0; fetch_addr 0..2 returns 0x05,0x41,0xC2.
REQ-035 Load 4 bytes with load_valid low for 3 cycles between bytes 2 and 3 -> load_count=4, memory correct, busy=1 throughout the load.
REQ-036 Load 256 bytes, none with load_last -> DONE, ovf=1, load_count=256, mem[255]=256th byte, mem[0] unchanged by wrap.
REQ-037 Assert reset after 2 of 5 bytes -> state IDLE, load_count=0; mem[0..1] new, mem[2..4] old contents.
REQ-038 load_start pulse mid-LOAD after byte 1 -> ignored; load_count continues to 2 after next byte.
REQ-039 With LOADER_CHECKSUM_EN: load 0xFF,0x02(last) -> checksum=0x01; new load_start -> checksum=0x00.
